// File: rtl/cla_pkg.sv
// cla_pkg: shared FSM state type and default geometry for the carry engine.
package cla_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    localparam int N_DEF   = 64;
    localparam int BLK_DEF = 4;
endpackage

// File: rtl/cla_carry_engine_group.sv
// cla_group: combinational BLK-bit lookahead cell; each carry is expanded
// independently from the group carry-in, so no ripple path exists in the cell.
module cla_group
    import cla_pkg::*;
#(
    parameter int BLK = BLK_DEF
) (
    input  logic [BLK-1:0] g,
    input  logic [BLK-1:0] p,
    input  logic           cin_group,
    output logic [BLK-1:0] c,
    output logic           cout_group
);
    function automatic logic carry_at(input int k, input logic [BLK-1:0] gg,
                                      input logic [BLK-1:0] pp, input logic ci);
        logic r;
        r = ci;
        for (int j = 0; j < k; j++) r = gg[j] | (pp[j] & r);
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < BLK; i++) c[i] = carry_at(i, g, p, cin_group);
        cout_group = carry_at(BLK, g, p, cin_group);
    end
endmodule

// File: rtl/cla_carry_engine.sv
// cla_carry_engine: multi-cycle carry generator resolving one BLK-bit lookahead group per cycle.
// Optional overflow output enabled by defining CLA_CARRY_ENGINE_OVF_EN.
module cla_carry_engine
    import cla_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int BLK = BLK_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cin,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] c,
    output logic [N-1:0] p,
    output logic         cout,
    input  logic         out_ready,
`ifdef CLA_CARRY_ENGINE_OVF_EN
    output logic         ovf,
    output logic         out_valid
`else
    output logic         out_valid
`endif
);
    localparam int NG = N / BLK;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;

    state_e         state_q;
    logic [N-1:0]   g_q, p_q, c_q;
    logic           cy_q, cout_q;
    logic [GW-1:0]  grp_q;
    logic [BLK-1:0] grp_c;
    logic           grp_cout;

    cla_group #(.BLK(BLK)) u_grp (
        .g          (g_q[grp_q*BLK +: BLK]),
        .p          (p_q[grp_q*BLK +: BLK]),
        .cin_group  (cy_q),
        .c          (grp_c),
        .cout_group (grp_cout)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign c         = c_q;
    assign p         = p_q;
    assign cout      = cout_q;

`ifdef CLA_CARRY_ENGINE_OVF_EN
    logic ovf_q;
    assign ovf = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) ovf_q <= 1'b0;
        else if (state_q == CALC && grp_q == GW'(NG - 1)) ovf_q <= grp_cout ^ grp_c[BLK-1];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
            c_q     <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            grp_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    g_q     <= a & b;
                    p_q     <= a ^ b;
                    cy_q    <= cin;
                    grp_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    c_q[grp_q*BLK +: BLK] <= grp_c;
                    cy_q <= grp_cout;
                    if (grp_q == GW'(NG - 1)) begin
                        cout_q  <= grp_cout;
                        grp_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        grp_q <= grp_q + 1'b1;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_carry_engine.sv
// tb_cla_carry_engine: table-driven vectors plus backpressure, ignored-input and reset-abort sequences.
module tb_cla_carry_engine;
    localparam int N = 64;
    localparam int BLK = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cin = 1'b0;
    logic [N-1:0]  a = '0, b = '0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic          in_ready, cout, out_valid;
    logic [N-1:0]  c, p;
`ifdef CLA_CARRY_ENGINE_OVF_EN
    logic          ovf;
`endif

    cla_carry_engine #(.N(N), .BLK(BLK)) dut (
        .clk(clk), .rst(rst), .cin(cin), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .c(c), .p(p), .cout(cout), .out_ready(out_ready),
`ifdef CLA_CARRY_ENGINE_OVF_EN
        .ovf(ovf),
`endif
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [64:0] sum;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic start(input logic [63:0] va, input logic [63:0] vb, input logic vc);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_wait", 65'(in_ready), 65'd1);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 65'(lat), 65'd16);
    endtask

    task automatic check_result(input vec_t v, input string tag);
        logic [63:0] exp_c;
        exp_c = v.sum[63:0] ^ v.a ^ v.b;
        chk({tag, "_out_valid"}, 65'(out_valid), 65'd1);
        chk({tag, "_c"}, 65'(c), 65'(exp_c));
        chk({tag, "_p"}, 65'(p), 65'(v.a ^ v.b));
        chk({tag, "_cout"}, 65'(cout), 65'(v.sum[64]));
`ifdef CLA_CARRY_ENGINE_OVF_EN
        chk({tag, "_ovf"}, 65'(ovf), 65'(v.sum[64] ^ exp_c[63]));
`endif
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_drain_out_valid"}, 65'(out_valid), 65'd0);
        chk({tag, "_drain_in_ready"}, 65'(in_ready), 65'd1);
    endtask

    initial begin
        vecs[0] = '{64'h0, 64'h0, 1'b0, 65'h0};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 65'h1_0000000000000000};
        vecs[2] = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b0, 65'h0_FFFFFFFFFFFFFFFF};
        vecs[3] = '{64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b1, 65'h1_0000000000000000};
        vecs[4] = '{64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 1'b0, 65'h1_1111111111111100};
        vecs[5] = '{64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 65'h0_8000000000000000};
        vecs[6] = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 65'h1_0000000000000000};
        vecs[7] = '{64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF, 1'b0, 65'h0_00000001FFFFFFFE};

        // operands presented while in reset must not start an operation
        in_valid = 1'b1; a = 64'h5; b = 64'h3; cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c", 65'(c), 65'd0);
        chk("rst_p", 65'(p), 65'd0);
        chk("rst_cout", 65'(cout), 65'd0);
        chk("rst_out_valid", 65'(out_valid), 65'd0);
        in_valid = 1'b0;
        rst = 1'b0;
        chk("post_rst_in_ready", 65'(in_ready), 65'd1);
        @(posedge clk);
        #1 chk("post_rst_still_idle", 65'(in_ready), 65'd1);

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].a, vecs[i].b, vecs[i].cin);
            wait_done($sformatf("v%0d", i));
            check_result(vecs[i], $sformatf("v%0d", i));
            drain($sformatf("v%0d", i));
        end

        // backpressure: hold DONE for 5 cycles while offering new operands
        start(vecs[4].a, vecs[4].b, vecs[4].cin);
        wait_done("bp");
        @(negedge clk);
        in_valid = 1'b1; a = 64'hDEAD; b = 64'hBEEF; cin = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_in_ready", k), 65'(in_ready), 65'd0);
            check_result(vecs[4], $sformatf("bp%0d", k));
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain("bp");

        // operands offered during CALC must be ignored
        start(vecs[3].a, vecs[3].b, vecs[3].cin);
        a = 64'hFFFFFFFFFFFFFFFF; b = 64'hFFFFFFFFFFFFFFFF; cin = 1'b0; in_valid = 1'b1;
        wait_done("ign");
        @(negedge clk);
        in_valid = 1'b0;
        check_result(vecs[3], "ign");
        drain("ign");

        // reset in the middle of CALC aborts, then a fresh operation completes
        start(vecs[4].a, vecs[4].b, vecs[4].cin);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_out_valid", 65'(out_valid), 65'd0);
        chk("abort_in_ready", 65'(in_ready), 65'd1);
        chk("abort_c", 65'(c), 65'd0);
        chk("abort_p", 65'(p), 65'd0);
        chk("abort_cout", 65'(cout), 65'd0);
        start(vecs[7].a, vecs[7].b, vecs[7].cin);
        wait_done("fresh");
        check_result(vecs[7], "fresh");
        drain("fresh");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_carry_engine.md
CLA_CARRY_ENGINE -- requirements
Module: cla_carry_engine

Interface
REQ-001 Parameter N, default 64, operand width in bits; N SHALL be a multiple of BLK.
REQ-002 Parameter BLK, default 4, bits resolved per cycle by one lookahead group.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cin  input  1  carry-in to bit 0, sampled with the operands.
REQ-006 a, b  input  N each  operands.
REQ-007 in_valid  input  1  operands valid; in_ready  output  1  engine can accept.
REQ-008 c  output  N  carry into each bit position; c[0] = cin.
REQ-009 p  output  N  propagate vector, a ^ b.
REQ-010 cout  output  1  carry out of bit N-1.
REQ-011 out_valid  output  1  c/p/cout valid; out_ready  input  1  downstream sum generator accepts.

Function
REQ-012 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer SHALL occur on a cycle with out_valid && out_ready.
REQ-013 FSM states: IDLE, CALC, DONE; IDLE->CALC on input transfer; CALC->DONE after the last group; DONE->IDLE on output transfer.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 On input transfer, a, b and cin SHALL be registered; g = a & b and p = a ^ b SHALL be formed from the registered values.
REQ-016 In CALC, one BLK-bit group per cycle SHALL be resolved, LSB group first, using full lookahead within the group and a registered inter-group carry.
REQ-017 Group counter SHALL run 0..N/BLK-1; CALC SHALL last exactly N/BLK cycles.
REQ-018 Latency: input transfer at edge T SHALL give out_valid high after edge T+N/BLK (N=64, BLK=4: 16 cycles).
REQ-019 cout SHALL equal carry out of the top group; {cout, c ^ p} SHALL equal a + b + cin.
REQ-020 Outputs SHALL hold stable in DONE while out_ready is low (backpressure, no data loss).
REQ-021 in_valid during CALC or DONE SHALL be ignored; operands SHALL NOT be overwritten.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 With N == BLK, CALC SHALL last one cycle.

Reset
REQ-024 rst high at any clock edge SHALL force IDLE, with c, p, cout, group counter and carry register zero and out_valid 0, aborting any operation in flight.
REQ-025 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-026 No input transfer SHALL be taken on a cycle where rst is high.

Configuration
REQ-027 Macro CLA_CARRY_ENGINE_OVF_EN: when defined, output ovf (1 bit) SHALL equal cout ^ c[N-1], with the same validity, hold and reset (0) rules as cout.
REQ-028 Without CLA_CARRY_ENGINE_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour unchanged.

Structure
REQ-029 Package cla_pkg SHALL hold the FSM state enum (IDLE/CALC/DONE) and the default N and BLK constants.
REQ-030 Sub-module cla_group: combinational BLK-bit lookahead cell (inputs g, p, cin_group; outputs carries and group carry-out), instantiated once and reused each cycle.
REQ-031 c and p SHALL connect directly to a downstream sum generator computing s = c ^ p.

Verification
REQ-032 a=0, b=0, cin=0 -> after 16 cycles c=0, p=0, cout=0.
REQ-033 a=all ones, b=0, cin=1 -> c=all ones, p=all ones, cout=1, c^p=0.
REQ-034 a=0xAAAAAAAAAAAAAAAA, b=0x5555555555555555, cin=0 -> p=all ones, c=0, cout=0; with cin=1 -> c=all ones, cout=1.
REQ-035 a=0x123456789ABCDEF0, b=0xFEDCBA9876543210, cin=0 -> {cout, c^p} = 0x1_1111111111111100; out_ready held low 5 cycles -> outputs unchanged, in_ready stays 0.
REQ-036 rst pulsed at cycle 8 of CALC -> next cycle IDLE, out_valid=0, in_ready=1; a fresh operation then completes correctly.
REQ-037 With CLA_CARRY_ENGINE_OVF_EN: a=0x7FFFFFFFFFFFFFFF, b=1 -> ovf=1; a=all ones, b=1 -> ovf=0.
